// File: rtl/inst_pipe_ctrl.sv
// inst_pipe_ctrl -- parametrised instruction-pipeline sequencer.
// Owns the fetch PC and the per-stage instruction/PC/valid registers. It handles
// per-stage stalls, redirect flushes (taken branch / PC write) and a lockstep
// mode in which only one instruction is in flight at a time.
// Optional feature macro: INST_PIPE_PERF_EN builds the retire/bubble
// performance counters. Without it, perf_retired and perf_bubbles are tied to 0.

module inst_pipe_ctrl #(
    parameter int                  WIDTH    = 32,
    parameter int                  PC_WIDTH = 32,
    parameter int                  STAGES   = 5,
    parameter int                  PC_INCR  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  SW       = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           fetch_inst,
    output logic [PC_WIDTH-1:0]        pc_curr,
    input  logic                       lockstep,
    input  logic [STAGES-1:0]          stall_req,
    input  logic                       redirect,
    input  logic [SW-1:0]              redirect_stage,
    input  logic [PC_WIDTH-1:0]        redirect_pc,
    output logic [STAGES*WIDTH-1:0]    stage_inst,
    output logic [STAGES*PC_WIDTH-1:0] stage_pc,
    output logic [STAGES-1:0]          stage_valid,
    output logic [SW-1:0]              cycle_state,
    output logic                       retire,
    output logic [31:0]                perf_retired,
    output logic [31:0]                perf_bubbles
);

    // Valid pattern meaning "only the writeback stage holds an instruction".
    localparam logic [STAGES-1:0] TOP_ONLY = {1'b1, {(STAGES-1){1'b0}}};

    // Reject parameter sets the stage indexing cannot represent.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("inst_pipe_ctrl: STAGES must be at least 2");
        end
        if ((1 << SW) < STAGES) begin : g_bad_sw
            $error("inst_pipe_ctrl: SW too narrow to index every stage");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    r_inst [STAGES];
    logic [PC_WIDTH-1:0] r_pc   [STAGES];
    logic [STAGES-1:0]   r_valid;
    logic [PC_WIDTH-1:0] r_pc_curr;
    logic [SW-1:0]       r_cycle_state;

    // ------------------------------------------------------------------
    // Control wires
    // ------------------------------------------------------------------
    logic [STAGES-1:0]   w_live_stall;   // stall requests from stages that hold a live instruction
    logic [STAGES-1:0]   w_hold;         // stage keeps its contents this cycle
    logic [STAGES-1:0]   w_rs_match;     // one-hot decode of redirect_stage (all zero if out of range)
    logic [STAGES-1:0]   w_flush;        // stage is younger than an honoured redirect
    logic [STAGES-1:0]   w_kill_in;      // stage's incoming instruction is wrong-path
    logic                w_redir;        // redirect honoured this cycle
    logic                w_retire;
    logic                w_fetch_en;
    logic                w_fetch;

    logic [WIDTH-1:0]    w_nxt_inst [STAGES];
    logic [PC_WIDTH-1:0] w_nxt_pc   [STAGES];
    logic [STAGES-1:0]   w_nxt_valid;
    logic [PC_WIDTH-1:0] w_nxt_pc_curr;
    logic [SW-1:0]       w_nxt_cycle_state;

    // An empty stage never stalls, whatever its request line says.
    assign w_live_stall = stall_req & r_valid;

    // Hold chain: a stage is held when it, or any older stage, stalls with a live instruction.
    always_comb begin
        logic w_acc;
        // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_hold = '0;
        w_acc  = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_acc     = w_acc | w_live_stall[k];
            w_hold[k] = w_acc;
        end
    end

    // Redirect decode: honoured only when the raising stage is live; flush everything younger.
    always_comb begin
        logic w_older;
        w_rs_match = '0;
        w_flush    = '0;
        w_kill_in  = '0;
        w_redir    = 1'b0;
        w_older    = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_rs_match[k] = (redirect_stage == SW'(k));
        end
        w_redir = redirect & (|(w_rs_match & r_valid));
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_flush[k]   = w_redir & w_older;
            w_kill_in[k] = w_redir & w_rs_match[k];
            w_older      = w_older | w_rs_match[k];
        end
    end

    // The writeback stage retires whenever it is live and not held.
    assign w_retire = r_valid[STAGES-1] & ~w_hold[STAGES-1];

    // Lockstep admits a new instruction only into an empty pipe or as the last one leaves.
    assign w_fetch_en = ~lockstep | (r_valid == '0) | ((r_valid == TOP_ONLY) & w_retire);
    assign w_fetch    = w_fetch_en & ~w_hold[0] & ~w_redir;

    // Next-state for the stage registers, fetch PC and lockstep cycle_state.
    always_comb begin
        w_nxt_inst        = r_inst;
        w_nxt_pc          = r_pc;
        w_nxt_valid       = r_valid;
        w_nxt_pc_curr     = r_pc_curr;
        w_nxt_cycle_state = '0;

        // Stage 0: flushed, held, loaded from fetch, or filled with a bubble.
        if (w_flush[0] || (!w_hold[0] && !w_fetch)) begin
            w_nxt_valid[0] = 1'b0;
            w_nxt_inst[0]  = '0;
            w_nxt_pc[0]    = '0;
        end else if (!w_hold[0]) begin
            w_nxt_valid[0] = 1'b1;
            w_nxt_inst[0]  = fetch_inst;
            w_nxt_pc[0]    = r_pc_curr;
        end

        // Later stages: flush beats stall; an advancing stage behind a held or
        // flushed neighbour takes a bubble, otherwise it takes its neighbour.
        for (int k = 1; k < STAGES; k++) begin
            if (w_flush[k] || (!w_hold[k] && (w_hold[k-1] || w_kill_in[k]))) begin
                w_nxt_valid[k] = 1'b0;
                w_nxt_inst[k]  = '0;
                w_nxt_pc[k]    = '0;
            end else if (!w_hold[k]) begin
                w_nxt_valid[k] = r_valid[k-1];
                w_nxt_inst[k]  = r_inst[k-1];
                w_nxt_pc[k]    = r_pc[k-1];
            end
        end

        // Redirect beats fetch; the PC wraps naturally at 2^PC_WIDTH.
        if (w_redir) begin
            w_nxt_pc_curr = redirect_pc;
        end else if (w_fetch) begin
            w_nxt_pc_curr = r_pc_curr + PC_WIDTH'(PC_INCR);
        end

        // In lockstep, report the oldest live stage (0 when the pipe is empty).
        if (lockstep) begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_nxt_valid[k]) begin
                    w_nxt_cycle_state = SW'(k);
                end
            end
        end
    end

    // Pipeline state registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_curr     <= RESET_PC;
            r_valid       <= '0;
            r_cycle_state <= '0;
            // NOTE: the stage arrays are ordinary flops rather than a RAM, so they are cleared by reset like any other register.
            for (int k = 0; k < STAGES; k++) begin
                r_inst[k] <= '0;
                r_pc[k]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
            r_pc_curr     <= w_nxt_pc_curr;
            r_valid       <= w_nxt_valid;
            r_cycle_state <= w_nxt_cycle_state;
            for (int k = 0; k < STAGES; k++) begin
                r_inst[k] <= w_nxt_inst[k];
                r_pc[k]   <= w_nxt_pc[k];
            end
        end
    end

`ifdef INST_PIPE_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_bubbles;

    // Saturating counters: retired instructions and cycles with an empty writeback stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_retired <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_retire && (r_perf_retired != 32'hFFFF_FFFF)) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (!r_valid[STAGES-1] && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_bubbles = r_perf_bubbles;
`else
    assign perf_retired = '0;
    assign perf_bubbles = '0;
`endif

    // Flatten the per-stage registers onto the packed output buses.
    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_pack
            assign stage_inst[g*WIDTH +: WIDTH]       = r_inst[g];
            assign stage_pc[g*PC_WIDTH +: PC_WIDTH]   = r_pc[g];
        end
    endgenerate

    assign pc_curr     = r_pc_curr;
    assign stage_valid = r_valid;
    assign cycle_state = r_cycle_state;
    assign retire      = w_retire;

endmodule

// File: tb/tb_inst_pipe_ctrl.sv
// Testbench for inst_pipe_ctrl: directed scenarios plus randomized stall,
// redirect and lockstep traffic, compared each cycle against a behavioural model.
`timescale 1ns/1ps

module tb_inst_pipe_ctrl;

    localparam int          STAGES   = 5;
    localparam int          SW       = 3;
    localparam logic [31:0] CODE_XOR = 32'hE000_0000;
    localparam logic [4:0]  TOP_ONLY = 5'b10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic        reset;
    logic [31:0] fetch_inst;
    logic [31:0] pc_curr;
    logic        lockstep;
    logic [4:0]  stall_req;
    logic        redirect;
    logic [2:0]  redirect_stage;
    logic [31:0] redirect_pc;
    logic [159:0] stage_inst;
    logic [159:0] stage_pc;
    logic [4:0]  stage_valid;
    logic [2:0]  cycle_state;
    logic        retire;
    logic [31:0] perf_retired;
    logic [31:0] perf_bubbles;

    // PC-wrap instance signals
    logic [31:0]  wr_fetch_inst;
    logic [31:0]  wr_pc_curr;
    logic         wr_lockstep  = 1'b0;
    logic [4:0]   wr_stall     = '0;
    logic         wr_redirect  = 1'b0;
    logic [2:0]   wr_rs        = '0;
    logic [31:0]  wr_rpc       = '0;
    logic [159:0] wr_stage_inst;
    logic [159:0] wr_stage_pc;
    logic [4:0]   wr_stage_valid;
    logic [2:0]   wr_cycle_state;
    logic         wr_retire;
    logic [31:0]  wr_perf_retired;
    logic [31:0]  wr_perf_bubbles;

    // code_mem stand-in: word is a fixed function of its address
    assign fetch_inst    = pc_curr ^ CODE_XOR;
    assign wr_fetch_inst = wr_pc_curr ^ CODE_XOR;

    inst_pipe_ctrl #(.STAGES(STAGES), .SW(SW)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_inst     (fetch_inst),
        .pc_curr        (pc_curr),
        .lockstep       (lockstep),
        .stall_req      (stall_req),
        .redirect       (redirect),
        .redirect_stage (redirect_stage),
        .redirect_pc    (redirect_pc),
        .stage_inst     (stage_inst),
        .stage_pc       (stage_pc),
        .stage_valid    (stage_valid),
        .cycle_state    (cycle_state),
        .retire         (retire),
        .perf_retired   (perf_retired),
        .perf_bubbles   (perf_bubbles)
    );

    inst_pipe_ctrl #(.STAGES(STAGES), .SW(SW), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .reset          (reset),
        .fetch_inst     (wr_fetch_inst),
        .pc_curr        (wr_pc_curr),
        .lockstep       (wr_lockstep),
        .stall_req      (wr_stall),
        .redirect       (wr_redirect),
        .redirect_stage (wr_rs),
        .redirect_pc    (wr_rpc),
        .stage_inst     (wr_stage_inst),
        .stage_pc       (wr_stage_pc),
        .stage_valid    (wr_stage_valid),
        .cycle_state    (wr_cycle_state),
        .retire         (wr_retire),
        .perf_retired   (wr_perf_retired),
        .perf_bubbles   (wr_perf_bubbles)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: slots indexed by stage, moved with whole-pipe rules
    // ------------------------------------------------------------------
    logic [31:0] m_inst [STAGES];
    logic [31:0] m_pc   [STAGES];
    logic [4:0]  m_valid;
    logic [31:0] m_pc_curr;
    int          m_cs;
    int unsigned m_retired;
    int unsigned m_bubbles;

    task automatic model_reset();
        for (int k = 0; k < STAGES; k++) begin
            m_inst[k] = '0;
            m_pc[k]   = '0;
        end
        m_valid   = '0;
        m_pc_curr = '0;
        m_cs      = 0;
        m_retired = 0;
        m_bubbles = 0;
    endtask

    // Highest stage that is live and requesting a stall, or -1.
    function automatic int high_stall();
        int h = -1;
        for (int k = 0; k < STAGES; k++) begin
            if (m_valid[k] && stall_req[k]) h = k;
        end
        return h;
    endfunction

    task automatic model_edge();
        int  h;
        int  rs;
        bit  redir;
        bit  fetch;
        bit  ret;
        h   = high_stall();
        ret = m_valid[STAGES-1] && (h < STAGES - 1);
        rs  = int'(redirect_stage);
        redir = 1'b0;
        if (redirect && rs < STAGES) redir = m_valid[rs];
        if (!m_valid[STAGES-1]) m_bubbles++;
        if (ret) m_retired++;
        fetch = !redir && (h < 0) &&
                (!lockstep || (m_valid == '0) || ((m_valid == TOP_ONLY) && ret));
        // Move oldest first: held stages stay, the one behind the stall gets a bubble
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (k <= h) begin
                // held in place
            end else if (h >= 0 && k == h + 1) begin
                m_valid[k] = 1'b0;
            end else if (k > 0) begin
                m_valid[k] = m_valid[k-1];
                m_inst[k]  = m_inst[k-1];
                m_pc[k]    = m_pc[k-1];
            end else if (fetch) begin
                m_valid[0] = 1'b1;
                m_inst[0]  = m_pc_curr ^ CODE_XOR;
                m_pc[0]    = m_pc_curr;
            end else begin
                m_valid[0] = 1'b0;
            end
        end
        // Redirect: everything younger than the branch is wrong-path
        if (redir) begin
            for (int k = 0; k < rs; k++) m_valid[k] = 1'b0;
            if (rs > h) m_valid[rs] = 1'b0;
            m_pc_curr = redirect_pc;
        end else if (fetch) begin
            m_pc_curr = m_pc_curr + 32'd4;
        end
        m_cs = 0;
        if (lockstep) begin
            for (int k = 0; k < STAGES; k++) if (m_valid[k]) m_cs = k;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [159:0] gi, ei, gp, ep;
        logic         exp_ret;
        logic [31:0]  exp_pr, exp_pb;
        gi = '0; ei = '0; gp = '0; ep = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (m_valid[k]) begin
                gi[k*32 +: 32] = stage_inst[k*32 +: 32];
                ei[k*32 +: 32] = m_inst[k];
                gp[k*32 +: 32] = stage_pc[k*32 +: 32];
                ep[k*32 +: 32] = m_pc[k];
            end
        end
        exp_ret = m_valid[STAGES-1] && (high_stall() < STAGES - 1);
`ifdef INST_PIPE_PERF_EN
        exp_pr = m_retired;
        exp_pb = m_bubbles;
`else
        exp_pr = '0;
        exp_pb = '0;
`endif
        check({tag, ":pc_curr"}, 256'(pc_curr), 256'(m_pc_curr));
        check({tag, ":valid"},   256'(stage_valid), 256'(m_valid));
        check({tag, ":inst"},    256'(gi), 256'(ei));
        check({tag, ":spc"},     256'(gp), 256'(ep));
        check({tag, ":retire"},  256'(retire), 256'(exp_ret));
        check({tag, ":cstate"},  256'(cycle_state), 256'(m_cs));
        check({tag, ":perf_r"},  256'(perf_retired), 256'(exp_pr));
        check({tag, ":perf_b"},  256'(perf_bubbles), 256'(exp_pb));
    endtask

    // Called at a negedge with inputs applied: compare, step model, cross the edge.
    task automatic run_cycle(input string tag);
        #1;
        compare_all(tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        lockstep       = 1'b0;
        stall_req      = '0;
        redirect       = 1'b0;
        redirect_stage = '0;
        redirect_pc    = '0;
    endtask

    // Assert reset for one cycle, check the cleared state, release at a negedge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < STAGES; k++) stall_req[k] = ($urandom_range(0, 7) == 0);
        redirect       = ($urandom_range(0, 9) == 0);
        redirect_stage = 3'($urandom_range(0, 7));
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 39) == 0) lockstep = ~lockstep;
    endtask

    initial begin
        int exp_cs [6];
        exp_cs = '{0, 1, 2, 3, 4, 0};
        reset = 1'b1;
        quiet_inputs();

        // 1: pipelined fill from reset; PC-wrap instance checked alongside
        do_reset("t1_reset");
        check("wrap_reset_pc", 256'(wr_pc_curr), 256'(32'hFFFF_FFFC));
        for (int i = 0; i < 5; i++) begin
            run_cycle("t1");
            if (i == 0) begin
                check("wrap_pc_next", 256'(wr_pc_curr), 256'(32'h0));
                check("wrap_s0_pc", 256'(wr_stage_pc[31:0]), 256'(32'hFFFF_FFFC));
            end
        end
        #1;
        check("t1_retire", 256'(retire), 256'(1'b1));
        check("t1_s4_pc", 256'(stage_pc[159:128]), 256'(32'h0));
        check("t1_s4_inst", 256'(stage_inst[159:128]), 256'(32'hE000_0000));
        check("t1_pc_curr", 256'(pc_curr), 256'(32'h14));
        check("t1_valid", 256'(stage_valid), 256'(5'b11111));

        // 2: lockstep cadence
        do_reset("t2_reset");
        lockstep = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_cycle("t2");
            #1;
            check("t2_cstate", 256'(cycle_state), 256'(exp_cs[i]));
            if (i == 0) check("t2_pc_a", 256'(pc_curr), 256'(32'h4));
            if (i == 4) check("t2_retire", 256'(retire), 256'(1'b1));
            if (i == 5) check("t2_pc_b", 256'(pc_curr), 256'(32'h8));
        end
        for (int i = 0; i < 6; i++) run_cycle("t2b");

        // 3: stall stage 2 for three cycles on a full pipe
        lockstep = 1'b0;
        do_reset("t3_reset");
        for (int i = 0; i < 5; i++) run_cycle("t3_fill");
        stall_req = 5'b00100;
        for (int i = 0; i < 3; i++) run_cycle("t3_stall");
        #1;
        check("t3_pc_frozen", 256'(pc_curr), 256'(32'h14));
        check("t3_valid", 256'(stage_valid), 256'(5'b00111));
        stall_req = '0;
        for (int i = 0; i < 8; i++) run_cycle("t3_resume");

        // 4: redirect from stage 2
        do_reset("t4_reset");
        for (int i = 0; i < 5; i++) run_cycle("t4_fill");
        redirect = 1'b1; redirect_stage = 3'd2; redirect_pc = 32'h100;
        run_cycle("t4_redir");
        redirect = 1'b0;
        #1;
        check("t4_valid_a", 256'(stage_valid), 256'(5'b11000));
        run_cycle("t4_after");
        #1;
        check("t4_s0_pc", 256'(stage_pc[31:0]), 256'(32'h100));
        check("t4_s4_pc", 256'(stage_pc[159:128]), 256'(32'h8));
        check("t4_retire", 256'(retire), 256'(1'b1));
        for (int i = 0; i < 4; i++) run_cycle("t4_tail");

        // 5: redirect beats a younger stall; redirect from a dead stage is ignored
        do_reset("t5_reset");
        for (int i = 0; i < 5; i++) run_cycle("t5_fill");
        redirect = 1'b1; redirect_stage = 3'd3; redirect_pc = 32'h300; stall_req = 5'b00010;
        run_cycle("t5_redir");
        #1;
        check("t5_valid", 256'(stage_valid), 256'(5'b10000));
        stall_req = '0; redirect_pc = 32'h200;
        run_cycle("t5_ignored");
        redirect = 1'b0;
        #1;
        check("t5_pc_inc", 256'(pc_curr), 256'(32'h304));
        for (int i = 0; i < 4; i++) run_cycle("t5_tail");

        // Randomized traffic with a mid-run reset
        quiet_inputs();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                quiet_inputs();
                do_reset("rand_reset");
            end
            rand_inputs();
            run_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
